// File: rtl/niosii_microprocessor_cpu_cpu_oci_dct_packer_pkg.sv
// Shared widths and FSM encoding for the OCI trace-frame packer.
package niosii_microprocessor_cpu_cpu_oci_dct_packer_pkg;
  localparam int DEF_FRAME_W = 2;
  localparam int DEF_FRAMES  = 15;
  localparam int DEF_BUF_W   = DEF_FRAME_W * DEF_FRAMES;
  localparam int DEF_CNT_W   = $clog2(DEF_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_e;
endpackage

// File: rtl/niosii_microprocessor_cpu_cpu_oci_dct_slot.sv
// Single-entry valid/ready output register holding one packed trace word.
module niosii_microprocessor_cpu_cpu_oci_dct_slot #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid
);
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;

  // A load overrides a same-cycle consume so back-to-back words see no bubble.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      count_d = load_count;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/niosii_microprocessor_cpu_cpu_oci_dct_packer.sv
// Packs 2-bit trace frames into 30-bit words with flush and end-of-test drain.
module niosii_microprocessor_cpu_cpu_oci_dct_packer
  import niosii_microprocessor_cpu_cpu_oci_dct_packer_pkg::*;
#(
  parameter int  FRAME_W = DEF_FRAME_W,
  parameter int  FRAMES  = DEF_FRAMES,
  localparam int BUF_W   = FRAME_W * FRAMES,
  localparam int CNT_W   = $clog2(FRAMES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               flush,
  input  logic               test_ending,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic [BUF_W-1:0]   word_data,
  output logic [CNT_W-1:0]   word_count,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               test_has_ended
);
  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, acc_buf_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d, acc_cnt_s;
  logic               pend_q, pend_d;
  logic               accept_s, slot_free_s, flush_req_s, commit_s;

  // The accumulator value after this cycle's frame is what a commit captures.
  always_comb begin
    frame_ready = (state_q == ST_RUN) && (cnt_q != CNT_W'(FRAMES)) && !pend_q;
    accept_s    = frame_valid && frame_ready;
    acc_buf_s   = buf_q;
    acc_cnt_s   = cnt_q;
    if (accept_s) begin
      acc_buf_s = {buf_q[BUF_W-FRAME_W-1:0], frame_data};
      acc_cnt_s = cnt_q + CNT_W'(1);
    end else begin
      acc_buf_s = buf_q;
      acc_cnt_s = cnt_q;
    end
    slot_free_s = !word_valid || word_ready;
    flush_req_s = flush || (state_q == ST_DRAIN);
    commit_s    = slot_free_s && (acc_cnt_s != '0) &&
                  ((acc_cnt_s == CNT_W'(FRAMES)) || flush_req_s || pend_q);

    buf_d  = acc_buf_s;
    cnt_d  = acc_cnt_s;
    pend_d = pend_q;
    if (commit_s) begin
      buf_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (flush_req_s && (acc_cnt_s != '0) && !slot_free_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Drain completes only once nothing is buffered, pending or waiting in the slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (test_ending) state_d = ST_DRAIN;
                else             state_d = ST_RUN;
      ST_DRAIN: if ((cnt_q == '0) && !pend_q && !word_valid) state_d = ST_ENDED;
                else                                         state_d = ST_DRAIN;
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  niosii_microprocessor_cpu_cpu_oci_dct_slot #(
    .DATA_W (BUF_W),
    .CNT_W  (CNT_W)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (commit_s),
    .load_data  (acc_buf_s),
    .load_count (acc_cnt_s),
    .out_ready  (word_ready),
    .out_data   (word_data),
    .out_count  (word_count),
    .out_valid  (word_valid)
  );

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == ST_ENDED);
endmodule

// File: tb/tb_niosii_microprocessor_cpu_cpu_oci_dct_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_niosii_microprocessor_cpu_cpu_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  frame_data = 2'd0;
  logic        frame_valid = 1'b0;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic        word_ready = 1'b0;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic        word_valid;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  // Reference model: accumulated frames as a queue, slot contents, pending flag, phase.
  int          m_acc[$];
  logic        m_wv;
  logic [29:0] m_wd;
  int          m_wc;
  bit          m_pend;
  int          m_phase;  // 0 running, 1 draining, 2 ended

  niosii_microprocessor_cpu_cpu_oci_dct_packer dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .word_data(word_data),
    .word_count(word_count), .word_valid(word_valid), .word_ready(word_ready),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  // Oldest frame is the most significant digit of a base-4 number.
  function automatic logic [29:0] pack_acc();
    longint v = 0;
    longint w = 1;
    for (int i = m_acc.size() - 1; i >= 0; i--) begin
      v = v + longint'(m_acc[i]) * w;
      w = w * 4;
    end
    return v[29:0];
  endfunction

  function automatic bit model_ready();
    return (m_phase == 0) && (m_acc.size() != 15) && !m_pend;
  endfunction

  task automatic model_reset();
    m_acc.delete();
    m_wv = 1'b0; m_wd = 30'd0; m_wc = 0; m_pend = 1'b0; m_phase = 0;
  endtask

  task automatic model_step();
    int  old_size  = m_acc.size();
    bit  old_pend  = m_pend;
    bit  old_wv    = m_wv;
    int  old_phase = m_phase;
    bit  free      = !m_wv || word_ready;
    bit  want      = flush || (old_phase == 1);
    if (frame_valid && model_ready()) m_acc.push_back(int'(frame_data));
    if (free && m_acc.size() > 0 && (m_acc.size() == 15 || want || m_pend)) begin
      m_wv = 1'b1; m_wd = pack_acc(); m_wc = m_acc.size();
      m_acc.delete(); m_pend = 1'b0;
    end else begin
      if (word_ready) m_wv = 1'b0;
      if (want && m_acc.size() > 0 && !free) m_pend = 1'b1;
    end
    if (old_phase == 0 && test_ending) m_phase = 1;
    else if (old_phase == 1 && old_size == 0 && !old_pend && !old_wv) m_phase = 2;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dct_buffer, dct_count, word_data, word_count, word_valid, test_has_ended} !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: got buf=%h cnt=%0d wd=%h wc=%0d wv=%b end=%b, want all 0",
               dct_buffer, dct_count, word_data, word_count, word_valid, test_has_ended);
    end
    model_reset();
    reset = 1'b0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", frame_ready);
    end
  endtask

  task automatic test_full_word();
    word_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      frame_valid = 1'b1; frame_data = 2'(i % 4);
      checks++;
      if (frame_ready !== 1'b1) begin
        errors++; $display("FAIL full_ready: frame %0d got %b want 1", i, frame_ready);
      end
      tick();
    end
    frame_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd15 || word_data !== 30'h06C6C6C6 || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL full_word: got wv=%b wc=%0d wd=%h cnt=%0d, want 1 15 06c6c6c6 0",
               word_valid, word_count, word_data, dct_count);
    end
    tick();
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL full_consume: got wv=%b want 0", word_valid);
    end
  endtask

  task automatic test_flush_hold();
    int seq[3] = '{3, 2, 1};
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1; frame_data = 2'(seq[i]);
      tick();
    end
    frame_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd3 || word_data !== 30'h39) begin
      errors++;
      $display("FAIL flush_word: got wv=%b wc=%0d wd=%h, want 1 3 39", word_valid, word_count, word_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (word_valid !== 1'b1 || word_count !== 4'd3 || word_data !== 30'h39) begin
        errors++;
        $display("FAIL flush_hold: cycle %0d got wv=%b wc=%0d wd=%h, want 1 3 39",
                 i, word_valid, word_count, word_data);
      end
    end
    word_ready = 1'b1;
    tick();
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL flush_consume: got wv=%b want 0", word_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] first_w;
    logic [29:0] second_w;
    int n = 0;
    word_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      frame_valid = 1'b1; frame_data = 2'($urandom);
      tick();
    end
    first_w = m_wd;
    while (dct_count !== 4'd15 && n < 40) begin
      frame_valid = 1'b1; frame_data = 2'($urandom);
      tick();
      n++;
    end
    checks++;
    if (dct_count !== 4'd15 || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: got cnt=%0d ready=%b after %0d cycles, want 15 0", dct_count, frame_ready, n);
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd15 || word_data !== first_w || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got wv=%b wc=%0d wd=%h ready=%b, want 1 15 %h 0",
               word_valid, word_count, word_data, frame_ready, first_w);
    end
    frame_valid = 1'b0;
    word_ready = 1'b1;
    second_w = pack_acc();
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd15 || word_data !== second_w || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_commit: got wv=%b wc=%0d wd=%h cnt=%0d, want 1 15 %h 0",
               word_valid, word_count, word_data, dct_count, second_w);
    end
    tick();
  endtask

  task automatic test_same_cycle_flush();
    word_ready = 1'b1;
    frame_valid = 1'b1; frame_data = 2'd1;
    tick();
    frame_data = 2'd2; flush = 1'b1;
    tick();
    frame_valid = 1'b0; flush = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_count !== 4'd2 || word_data !== 30'h6 || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL same_cycle_flush: got wv=%b wc=%0d wd=%h cnt=%0d, want 1 2 6 0",
               word_valid, word_count, word_data, dct_count);
    end
    tick();
  endtask

  task automatic test_drain();
    logic [29:0] exp_w;
    bit seen = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_valid = 1'b1; frame_data = 2'($urandom);
      tick();
    end
    exp_w = pack_acc();
    frame_valid = 1'b0; test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (word_valid === 1'b1 && word_count === 4'd5 && word_data === exp_w) seen = 1'b1;
      if (test_has_ended === 1'b1) break;
      tick();
    end
    checks++;
    if (!seen || test_has_ended !== 1'b1) begin
      errors++;
      $display("FAIL drain: got seen_word=%b ended=%b, want 1 1 (word %h)", seen, test_has_ended, exp_w);
    end
    frame_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (frame_ready !== 1'b0 || test_has_ended !== 1'b1 || dct_count !== 4'd0) begin
        errors++;
        $display("FAIL ended_absorb: cycle %0d got ready=%b ended=%b cnt=%0d, want 0 1 0",
                 i, frame_ready, test_has_ended, dct_count);
      end
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1; frame_data = 2'($urandom);
      tick();
    end
    frame_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      frame_valid = 1'b1; frame_data = 2'($urandom);
      tick();
    end
    frame_valid = 1'b0;
    checks++;
    if (dct_count !== 4'd9 || word_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got cnt=%0d wv=%b, want 9 1", dct_count, word_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dct_buffer, dct_count, word_data, word_count, word_valid, test_has_ended} !== 66'd0) begin
      errors++;
      $display("FAIL mid_reset: got buf=%h cnt=%0d wd=%h wc=%0d wv=%b end=%b, want all 0",
               dct_buffer, dct_count, word_data, word_count, word_valid, test_has_ended);
    end
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release_ready: got %b want 1", frame_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      frame_valid = ($urandom_range(0, 3) != 0);
      frame_data  = 2'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      word_ready  = ($urandom_range(0, 2) != 0);
      test_ending = (i > 700) && ($urandom_range(0, 39) == 0);
      checks++;
      if (frame_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", i, frame_ready, model_ready());
      end
      tick();
      checks++;
      if (dct_count !== 4'(m_acc.size()) || dct_buffer !== pack_acc() || word_valid !== m_wv ||
          test_has_ended !== (m_phase == 2) ||
          (m_wv && (word_data !== m_wd || word_count !== 4'(m_wc)))) begin
        errors++;
        $display("FAIL rand_state: cycle %0d got cnt=%0d buf=%h wv=%b wd=%h wc=%0d end=%b, want %0d %h %b %h %0d %b",
                 i, dct_count, dct_buffer, word_valid, word_data, word_count, test_has_ended,
                 m_acc.size(), pack_acc(), m_wv, m_wd, m_wc, (m_phase == 2));
      end
    end
    frame_valid = 1'b0; flush = 1'b0; test_ending = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_word();
    test_flush_hold();
    test_back_to_back();
    test_same_cycle_flush();
    test_drain();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
